// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-ported data RAM between instruction fetch (read-only) and the
// memory stage (read/write with bit mask); MEM has priority, IF is protected from starvation.
module ram_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_wmask,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,

    output logic              err,

    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] ram_wmask,
    input  logic              ram_ack,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC_IF  = 2'd1,
        ACC_MEM = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYC - 1);
    localparam bit         TMO_EN     = (TIMEOUT_CYC != 0);

    state_e            state_q;
    logic [3:0]        starve_q;
    logic [7:0]        tmo_q;

    logic              if_gnt_q, if_rvalid_q;
    logic              mem_gnt_q, mem_rvalid_q;
    logic              err_q;
    logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
    logic              ram_req_q, ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q, ram_wmask_q;

    logic              take_if_d, take_mem_d;
    logic              tmo_hit_d, acc_done_d;
    logic [DATA_W-1:0] resp_data_d;
    logic [3:0]        starve_inc_d;

    // Arbitration decision and access completion, evaluated against the current state.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        take_if_d    = 1'b0;
        take_mem_d   = 1'b0;
        tmo_hit_d    = 1'b0;
        resp_data_d  = '0;
        starve_inc_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;

        if (state_q == IDLE) begin
            if (mem_req && !(if_req && starve_q == STARVE_MAX)) begin
                take_mem_d = 1'b1;
            end else if (if_req) begin
                take_if_d = 1'b1;
            end
        end

        if (TMO_EN && tmo_q == TMO_LAST) begin
            tmo_hit_d = 1'b1;
        end
        // An ack arriving on the last allowed cycle still completes the access normally.
        acc_done_d = ram_ack || tmo_hit_d;

        if (ram_ack && !ram_we_q) begin
            resp_data_d = ram_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so every register
            // sees the pre-edge values of the others.
            state_q      <= IDLE;
            starve_q     <= '0;
            tmo_q        <= '0;
            if_gnt_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            mem_gnt_q    <= 1'b0;
            mem_rvalid_q <= 1'b0;
            err_q        <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            ram_req_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_wmask_q  <= '0;
        end else begin
            if_gnt_q     <= 1'b0;
            mem_gnt_q    <= 1'b0;
            if_rvalid_q  <= 1'b0;
            mem_rvalid_q <= 1'b0;
            err_q        <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (take_mem_d) begin
                        state_q     <= ACC_MEM;
                        mem_gnt_q   <= 1'b1;
                        ram_req_q   <= 1'b1;
                        ram_we_q    <= mem_we;
                        ram_addr_q  <= mem_addr;
                        ram_wdata_q <= mem_wdata;
                        ram_wmask_q <= mem_wmask;
                        tmo_q       <= '0;
                        starve_q    <= if_req ? starve_inc_d : 4'd0;
                    end else if (take_if_d) begin
                        state_q     <= ACC_IF;
                        if_gnt_q    <= 1'b1;
                        ram_req_q   <= 1'b1;
                        ram_we_q    <= 1'b0;
                        ram_addr_q  <= if_addr;
                        ram_wdata_q <= '0;
                        ram_wmask_q <= '0;
                        tmo_q       <= '0;
                        starve_q    <= '0;
                    end
                end

                ACC_IF, ACC_MEM: begin
                    if (acc_done_d) begin
                        state_q   <= RESP;
                        ram_req_q <= 1'b0;
                        tmo_q     <= '0;
                        err_q     <= !ram_ack;
                        if (state_q == ACC_IF) begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= resp_data_d;
                        end else begin
                            mem_rvalid_q <= 1'b1;
                            mem_rdata_q  <= resp_data_d;
                        end
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end

                RESP: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_gnt     = if_gnt_q;
    assign if_rvalid  = if_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign mem_gnt    = mem_gnt_q;
    assign mem_rvalid = mem_rvalid_q;
    assign mem_rdata  = mem_rdata_q;
    assign err        = err_q;
    assign ram_req    = ram_req_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_wmask  = ram_wmask_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: reset, single accesses, starvation order,
// back-to-back turnaround, timeout recovery and reset abort of an in-flight access.
module tb_ram_port_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_wmask;
    logic          mem_gnt, mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          err;
    logic          ram_req, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_wmask;
    logic          ram_ack;
    logic [DW-1:0] ram_rdata;

    logic          auto_ack;
    logic          man_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Auto mode acks in the first cycle ram_req is seen (zero latency).
    assign ram_ack = auto_ack ? ram_req : man_ack;

    ram_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .STARVE_LIMIT(4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .err       (err),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wmask (ram_wmask),
        .ram_ack   (ram_ack),
        .ram_rdata (ram_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic any_out();
        return |{if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata, err,
                 ram_req, ram_we, ram_addr, ram_wdata, ram_wmask};
    endfunction

    initial begin
        string seq;
        string exp_seq;
        int    n_gnt;
        int    both;
        int    hi;
        int    rv_cnt;
        int    last_rv;
        logic  seen_rv;
        logic [AW-1:0] b2b_addr [4];
        logic [DW-1:0] b2b_data [4];

        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        ram_rdata = '0;
        auto_ack  = 1'b0;
        man_ack   = 1'b0;

        // Reset state
        step();
        check("reset_outputs_zero", 64'(any_out()), 64'd0);
        step();
        rst = 1'b1;
        step();

        // Single IF read, ack one cycle after ram_req
        if_req  = 1'b1;
        if_addr = 64'h8000_0000;
        step();
        check("if_gnt_t1",    64'(if_gnt), 64'd1);
        check("if_ram_req",   64'(ram_req), 64'd1);
        check("if_ram_addr",  ram_addr, 64'h8000_0000);
        check("if_ram_we",    64'(ram_we), 64'd0);
        check("if_ram_wmask", ram_wmask, 64'd0);
        check("if_no_mem_gnt", 64'(mem_gnt), 64'd0);
        if_req = 1'b0;
        step();
        check("if_gnt_pulse", 64'(if_gnt), 64'd0);
        check("if_req_held",  64'(ram_req), 64'd1);
        man_ack   = 1'b1;
        ram_rdata = 64'h0000_0013_0000_0093;
        step();
        man_ack = 1'b0;
        check("if_rvalid_t3", 64'(if_rvalid), 64'd1);
        check("if_rdata",     if_rdata, 64'h0000_0013_0000_0093);
        check("if_err",       64'(err), 64'd0);
        check("if_req_drop",  64'(ram_req), 64'd0);
        step();
        check("if_rvalid_pulse", 64'(if_rvalid), 64'd0);
        check("if_rdata_hold",   if_rdata, 64'h0000_0013_0000_0093);

        // MEM byte store; RAM read data present but must be forced to 0
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 64'h8000_1003;
        mem_wdata = 64'hAB00_0000;
        mem_wmask = 64'hFF00_0000;
        ram_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        check("st_gnt",   64'(mem_gnt), 64'd1);
        check("st_we",    64'(ram_we), 64'd1);
        check("st_addr",  ram_addr, 64'h8000_1003);
        check("st_wdata", ram_wdata, 64'hAB00_0000);
        check("st_wmask", ram_wmask, 64'hFF00_0000);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_wmask = '0;
        man_ack   = 1'b1;
        step();
        man_ack = 1'b0;
        check("st_rvalid", 64'(mem_rvalid), 64'd1);
        check("st_rdata",  mem_rdata, 64'd0);
        check("st_err",    64'(err), 64'd0);
        check("st_if_rvalid", 64'(if_rvalid), 64'd0);
        step();

        // Both requesters held: MEM x4 then IF, repeating
        auto_ack  = 1'b1;
        ram_rdata = 64'h55;
        if_req    = 1'b1;
        if_addr   = 64'h4000;
        mem_req   = 1'b1;
        mem_addr  = 64'h5000;
        seq       = "";
        exp_seq   = "MMMMIMMMMI";
        n_gnt     = 0;
        both      = 0;
        for (int i = 0; i < 40 && n_gnt < 10; i++) begin
            step();
            if ((if_gnt && mem_gnt) || (if_rvalid && mem_rvalid)) both++;
            if (mem_gnt) begin
                seq = {seq, "M"};
                n_gnt++;
            end else if (if_gnt) begin
                seq = {seq, "I"};
                n_gnt++;
            end
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
        check("starve_gnt_count", 64'(n_gnt), 64'd10);
        check("starve_both_gnt",  64'(both), 64'd0);
        for (int i = 0; i < 10; i++) begin
            if (i < seq.len()) check($sformatf("starve_order_%0d", i), 64'(seq[i]), 64'(exp_seq[i]));
        end
        step();
        step();
        step();

        // Back-to-back MEM reads with zero ack latency: rvalid every 3 cycles
        b2b_addr = '{64'hA0, 64'hA8, 64'hB0, 64'hB8};
        b2b_data = '{64'h1111_2222_3333_4444, 64'h0102_0304_0506_0708,
                     64'hCAFE_0000_0000_0001, 64'hFFFF_0000_FFFF_0000};
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = b2b_addr[0];
        ram_rdata = b2b_data[0];
        rv_cnt    = 0;
        n_gnt     = 0;
        last_rv   = -1;
        for (int cyc = 0; cyc < 20 && rv_cnt < 4; cyc++) begin
            step();
            if (mem_gnt) begin
                if (n_gnt < 4) check($sformatf("b2b_addr_%0d", n_gnt), ram_addr, b2b_addr[n_gnt]);
                n_gnt++;
            end
            if (mem_rvalid) begin
                check($sformatf("b2b_rdata_%0d", rv_cnt), mem_rdata, b2b_data[rv_cnt]);
                if (last_rv >= 0) check($sformatf("b2b_gap_%0d", rv_cnt), 64'(cyc - last_rv), 64'd3);
                last_rv = cyc;
                rv_cnt++;
                if (rv_cnt < 4) begin
                    mem_addr  = b2b_addr[rv_cnt];
                    ram_rdata = b2b_data[rv_cnt];
                end else begin
                    mem_req = 1'b0;
                end
            end
        end
        mem_req = 1'b0;
        check("b2b_rvalid_count", 64'(rv_cnt), 64'd4);
        auto_ack = 1'b0;
        step();

        // Timeout: MEM read never acked
        mem_req   = 1'b1;
        mem_addr  = 64'h100;
        ram_rdata = 64'h7777;
        hi        = 0;
        seen_rv   = 1'b0;
        for (int cyc = 0; cyc < 20 && !seen_rv; cyc++) begin
            step();
            if (mem_gnt) mem_req = 1'b0;
            if (mem_rvalid) begin
                seen_rv = 1'b1;
                check("tmo_err",   64'(err), 64'd1);
                check("tmo_rdata", mem_rdata, 64'd0);
                check("tmo_ram_req_low", 64'(ram_req), 64'd0);
                if_req  = 1'b1;
                if_addr = 64'h200;
            end else if (ram_req) begin
                hi++;
            end
        end
        mem_req = 1'b0;
        check("tmo_rvalid_seen", 64'(seen_rv), 64'd1);
        check("tmo_req_cycles",  64'(hi), 64'd8);
        step();
        check("resp_not_sampled", 64'(if_gnt), 64'd0);
        check("tmo_err_pulse",    64'(err), 64'd0);
        step();
        check("post_tmo_if_gnt",  64'(if_gnt), 64'd1);
        check("post_tmo_addr",    ram_addr, 64'h200);
        if_req    = 1'b0;
        man_ack   = 1'b1;
        ram_rdata = 64'h1234_5678;
        step();
        man_ack = 1'b0;
        check("post_tmo_rvalid", 64'(if_rvalid), 64'd1);
        check("post_tmo_rdata",  if_rdata, 64'h1234_5678);
        check("post_tmo_err",    64'(err), 64'd0);
        step();

        // Reset asserted mid-ACC_MEM; late ack after release ignored
        mem_req  = 1'b1;
        mem_addr = 64'h300;
        step();
        check("rst_pre_gnt", 64'(mem_gnt), 64'd1);
        mem_req = 1'b0;
        step();
        check("rst_pre_req", 64'(ram_req), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_zero", 64'(any_out()), 64'd0);
        man_ack   = 1'b1;
        ram_rdata = 64'h9999;
        step();
        rst = 1'b1;
        hi  = 0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            step();
            if (if_rvalid || mem_rvalid || err || ram_req || if_gnt || mem_gnt) hi++;
        end
        man_ack = 1'b0;
        check("rst_late_ack_ignored", 64'(hi), 64'd0);
        check("rst_mem_rdata", mem_rdata, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-ported data RAM between two requesters: instruction fetch (IF, read-only) and the memory stage (MEM, read/write with byte mask).
- Sits between the pipeline stages and the RAM model.
- Serialises accesses through a request/ack handshake and returns completion plus read data to the granted requester.
- MEM has priority; a starvation counter guarantees IF forward progress; an ack timeout prevents lock-up.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data and mask width (mask is one bit per data bit)
STARVE_LIMIT, 4, consecutive MEM wins over a pending IF before IF is forced; range 1..15
TIMEOUT_CYC, 64, cycles in an access state without ram_ack before abort; 0 disables; range 0..255

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-low reset (rst==0 resets)
if_req  in  1  IF access request
if_addr  in  ADDR_W  IF fetch address
if_gnt  out  1  one-cycle pulse: IF request latched
if_rvalid  out  1  one-cycle pulse: IF access complete
if_rdata  out  DATA_W  IF read data, valid with if_rvalid
mem_req  in  1  MEM access request
mem_we  in  1  1 = write, 0 = read
mem_addr  in  ADDR_W  MEM address
mem_wdata  in  DATA_W  already-shifted store data
mem_wmask  in  DATA_W  store bit mask
mem_gnt  out  1  one-cycle pulse: MEM request latched
mem_rvalid  out  1  one-cycle pulse: MEM access complete
mem_rdata  out  DATA_W  raw 64-bit RAM word, valid with mem_rvalid
err  out  1  pulse coincident with rvalid when the access timed out
ram_req  out  1  RAM access strobe, held until ram_ack
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_wmask  out  DATA_W  RAM write mask
ram_ack  in  1  RAM completion; one cycle
ram_rdata  in  DATA_W  RAM read data, valid with ram_ack

Behaviour:
- Reset (rst==0, asynchronous):
  - State goes to IDLE.
  - Every output is 0; starvation and timeout counters are 0.
  - An in-flight access is abandoned. A ram_ack arriving after reset release while in IDLE is ignored.
- States: IDLE, ACC_IF, ACC_MEM, RESP. Every output is registered.
- IDLE: requests are sampled on the clock edge.
  - mem_req only -> ACC_MEM.
  - if_req only -> ACC_IF.
  - Both asserted -> ACC_MEM, unless starve_cnt==STARVE_LIMIT, in which case ACC_IF.
  - Neither -> stay in IDLE.
- Request latch on entering ACC_x:
  - Address, we, wdata and wmask are captured into ram_* and ram_req=1.
  - The matching gnt pulses for exactly the first ACC cycle.
  - IF accesses always drive ram_we=0 and ram_wmask=0.
- Starvation counter:
  - Increments on each MEM grant taken while if_req=1, saturating at STARVE_LIMIT.
  - Clears on any IF grant.
  - Clears on a MEM grant with if_req=0.
- Requester rules:
  - Inputs must be held stable until gnt is seen.
  - Inputs may change freely after gnt.
  - A request still asserted after its rvalid is treated as a new request.
- ACC_x:
  - ram_* are held constant; ram_req stays 1; the timeout counter increments each cycle.
  - On ram_ack: capture ram_rdata (forced to 0 for writes), ram_req drops next cycle, go to RESP.
  - If TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC without ram_ack: go to RESP with data 0 and set err.
- RESP (one cycle):
  - The owner's rvalid=1 with its rdata; err is 1 only on a timed-out access.
  - Writes also produce rvalid, as a completion pulse.
  - The next state is always IDLE; nothing is sampled in RESP.
- Latency:
  - Request at edge T -> gnt and ram_req in cycle T+1.
  - ram_ack in cycle T+1+k -> rvalid in cycle T+2+k.
  - Minimum turnaround is 3 cycles per access: req, ack, rvalid.
- ram_ack outside ACC states is ignored.
- rdata outputs hold their last value between pulses; they are valid only with rvalid.
- At most one access is outstanding; gnt and rvalid are never asserted for both requesters in the same cycle.

Test Plan:
- Reset: rst=0 pulsed mid-ACC_MEM with ram_req=1 -> all outputs 0 immediately; a late ram_ack is ignored; no rvalid appears.
- Single IF read: if_req, if_addr=0x8000_0000, ram_ack one cycle after ram_req with rdata=0x0000_0013_0000_0093 -> if_gnt at T+1; ram_addr=0x8000_0000, ram_we=0, ram_wmask=0; if_rvalid with that data at T+3.
- MEM byte store: mem_we=1, addr=0x8000_1003, wdata=0xAB00_0000, wmask=0xFF00_0000 -> ram_* carry those exact values; mem_rvalid with mem_rdata=0.
- Conflict and starvation with STARVE_LIMIT=4: both requesters held continuously -> grant order MEM, MEM, MEM, MEM, IF, MEM, ... with no cycle granting both.
- Timeout with TIMEOUT_CYC=8: MEM read, ram_ack never asserted -> ram_req high 8 cycles, then mem_rvalid=1, err=1, mem_rdata=0; the next IF request is served normally.
- Back-to-back MEM requests with mem_req held high and ack latency 0 -> mem_rvalid every 3 cycles; the input presented after each rvalid is accepted as a new request.
